// File: rtl/pl_ifid_queue.sv
// IF/ID stage: DEPTH-entry prefetch queue feeding a registered decode/operand bundle for EX.
// Fetch-to-ID is two edges minimum; a branch flush empties the queue and the ID register on the next edge.
module pl_ifid_queue #(
  parameter int PROG_CTR_WID = 10,
  parameter int NUM_DOMAINS  = 1,
  parameter int DEPTH        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_valid,
  input  logic [PROG_CTR_WID-1:0]       if_pc,
  input  logic [15:0]                   if_instr,
  output logic                          if_ready,
  input  logic                          flush,
  input  logic                          id_stall,
  output logic [2:0]                    op1_addr_fwd,
  output logic [2:0]                    op2_addr_fwd,
  output logic                          load_fwd,
  input  logic [NUM_DOMAINS*8-1:0]      op1_data,
  input  logic [NUM_DOMAINS*8-1:0]      op2_data,
  output logic                          id_valid,
  output logic [PROG_CTR_WID-1:0]       id_pc,
  output logic [20:0]                   id_ctrl,
  output logic [2:0]                    id_op1_addr,
  output logic [2:0]                    id_op2_addr,
  output logic [2:0]                    id_res_addr,
  output logic [7:0]                    id_ld_addr,
  output logic [7:0]                    id_st_addr,
  output logic [PROG_CTR_WID-1:0]       id_br_target,
  output logic [NUM_DOMAINS*8-1:0]      id_op1,
  output logic [NUM_DOMAINS*8-1:0]      id_op2,
  output logic [$clog2(DEPTH):0]        q_count
);
  localparam int PCW = PROG_CTR_WID;
  localparam int OPW = NUM_DOMAINS * 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  logic [PCW-1:0] pc_mem_q    [DEPTH];
  logic [15:0]    instr_mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

  logic           id_valid_q, id_valid_d;
  logic [PCW-1:0] id_pc_q, id_pc_d, id_br_q, id_br_d;
  logic [20:0]    id_ctrl_q, id_ctrl_d;
  logic [2:0]     id_op1a_q, id_op1a_d, id_op2a_q, id_op2a_d, id_resa_q, id_resa_d;
  logic [7:0]     id_ld_q, id_ld_d, id_st_q, id_st_d;
  logic [OPW-1:0] id_op1_q, id_op1_d, id_op2_q, id_op2_d;

  logic           empty, push, adv, pop;
  logic [15:0]    head_instr;
  logic [PCW-1:0] head_pc, head_br;
  logic [4:0]     head_op;

  function automatic logic [20:0] decode(input logic [4:0] op);
    logic [20:0] c;
    c = '0;
    case (op)
      5'h01: begin c[0] = 1'b1; c[15] = 1'b1; end
      5'h02: begin c[0] = 1'b1; c[7] = 1'b1; c[8] = 1'b1; c[15] = 1'b1; end
      5'h03: begin c[1] = 1'b1; c[12] = 1'b1; c[15] = 1'b1; end
      5'h04: begin c[2] = 1'b1; c[12] = 1'b1; c[15] = 1'b1; end
      5'h05: begin c[3] = 1'b1; c[12] = 1'b1; c[15] = 1'b1; end
      5'h06: begin c[11] = 1'b1; c[15] = 1'b1; end
      5'h07: begin c[9] = 1'b1; c[16] = 1'b1; end
      5'h08: begin c[13] = 1'b1; c[15] = 1'b1; end
      5'h09: begin c[14] = 1'b1; end
      5'h0A: begin c[4] = 1'b1; c[12] = 1'b1; c[15] = 1'b1; end
      5'h0B: begin c[5] = 1'b1; c[12] = 1'b1; c[15] = 1'b1; end
      5'h0C: begin c[6] = 1'b1; c[12] = 1'b1; c[15] = 1'b1; end
      5'h0D: begin c[0] = 1'b1; c[7] = 1'b1; c[8] = 1'b1; c[10] = 1'b1; end
      5'h0E: begin c[9] = 1'b1; c[17] = 1'b1; end
      5'h0F: begin c[9] = 1'b1; c[18] = 1'b1; end
      5'h10: begin c[9] = 1'b1; c[19] = 1'b1; end
      5'h11: begin c[9] = 1'b1; c[20] = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign head_instr = instr_mem_q[rd_ptr_q];
  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_op    = head_instr[15:11];
  assign empty      = (count_q == '0);
  // if_ready is purely from occupancy: a pop does not free a slot in the same cycle
  assign if_ready   = (count_q != CW'(DEPTH));
  assign push       = if_valid && if_ready && !flush;
  assign adv        = !id_valid_q || !id_stall;
  assign pop        = adv && !empty && !flush;

  generate
    if (PCW > 10) begin : g_br_ext
      assign head_br = {{(PCW-10){1'b0}}, head_instr[9:0]};
    end else if (PCW == 10) begin : g_br_eq
      assign head_br = head_instr[9:0];
    end else begin : g_br_trunc
      assign head_br = head_instr[PCW-1:0];
    end
  endgenerate

  assign op1_addr_fwd = head_instr[2:0];
  assign op2_addr_fwd = head_instr[6:4];
  assign load_fwd     = !empty && (head_op == 5'h08);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= if_pc;
      instr_mem_q[wr_ptr_q] <= if_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_ctrl_d  = id_ctrl_q;
    id_op1a_d  = id_op1a_q;
    id_op2a_d  = id_op2a_q;
    id_resa_d  = id_resa_q;
    id_ld_d    = id_ld_q;
    id_st_d    = id_st_q;
    id_br_d    = id_br_q;
    id_op1_d   = id_op1_q;
    id_op2_d   = id_op2_q;
    if (flush || (adv && empty)) begin
      id_valid_d = 1'b0;
      id_pc_d    = '0;
      id_ctrl_d  = '0;
      id_op1a_d  = '0;
      id_op2a_d  = '0;
      id_resa_d  = '0;
      id_ld_d    = '0;
      id_st_d    = '0;
      id_br_d    = '0;
      id_op1_d   = '0;
      id_op2_d   = '0;
    end else if (adv) begin
      id_valid_d = 1'b1;
      id_pc_d    = head_pc;
      id_ctrl_d  = decode(head_op);
      id_op1a_d  = head_instr[2:0];
      id_op2a_d  = head_instr[6:4];
      id_resa_d  = head_instr[10:8];
      id_ld_d    = head_instr[7:0];
      id_st_d    = head_instr[10:3];
      id_br_d    = head_br;
      id_op1_d   = op1_data;
      id_op2_d   = op2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_ctrl_q  <= '0;
      id_op1a_q  <= '0;
      id_op2a_q  <= '0;
      id_resa_q  <= '0;
      id_ld_q    <= '0;
      id_st_q    <= '0;
      id_br_q    <= '0;
      id_op1_q   <= '0;
      id_op2_q   <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_ctrl_q  <= id_ctrl_d;
      id_op1a_q  <= id_op1a_d;
      id_op2a_q  <= id_op2a_d;
      id_resa_q  <= id_resa_d;
      id_ld_q    <= id_ld_d;
      id_st_q    <= id_st_d;
      id_br_q    <= id_br_d;
      id_op1_q   <= id_op1_d;
      id_op2_q   <= id_op2_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_ctrl      = id_ctrl_q;
  assign id_op1_addr  = id_op1a_q;
  assign id_op2_addr  = id_op2a_q;
  assign id_res_addr  = id_resa_q;
  assign id_ld_addr   = id_ld_q;
  assign id_st_addr   = id_st_q;
  assign id_br_target = id_br_q;
  assign id_op1       = id_op1_q;
  assign id_op2       = id_op2_q;
  assign q_count      = count_q;
endmodule

// File: tb/tb_pl_ifid_queue.sv
// Bench for pl_ifid_queue (8-bit PC, 3 operand lanes, 4-entry queue): directed cases plus a
// scoreboard that tracks queue contents and the ID register independently of the design.
module tb_pl_ifid_queue;
  localparam int PCW   = 8;
  localparam int ND    = 3;
  localparam int DEPTH = 4;
  localparam int OPW   = ND * 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           if_valid, if_ready, flush, id_stall, load_fwd, id_valid;
  logic [PCW-1:0] if_pc, id_pc, id_br_target;
  logic [15:0]    if_instr;
  logic [2:0]     op1_addr_fwd, op2_addr_fwd, id_op1_addr, id_op2_addr, id_res_addr;
  logic [OPW-1:0] op1_data, op2_data, id_op1, id_op2;
  logic [20:0]    id_ctrl;
  logic [7:0]     id_ld_addr, id_st_addr;
  logic [2:0]     q_count;

  always #5 clk = ~clk;

  pl_ifid_queue #(.PROG_CTR_WID(PCW), .NUM_DOMAINS(ND), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .id_stall(id_stall),
    .op1_addr_fwd(op1_addr_fwd), .op2_addr_fwd(op2_addr_fwd), .load_fwd(load_fwd),
    .op1_data(op1_data), .op2_data(op2_data), .id_valid(id_valid), .id_pc(id_pc),
    .id_ctrl(id_ctrl), .id_op1_addr(id_op1_addr), .id_op2_addr(id_op2_addr),
    .id_res_addr(id_res_addr), .id_ld_addr(id_ld_addr), .id_st_addr(id_st_addr),
    .id_br_target(id_br_target), .id_op1(id_op1), .id_op2(id_op2), .q_count(q_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [20:0] exp_ctrl(input logic [4:0] op);
    logic [20:0] c;
    c = '0;
    case (op)
      5'h01: c = 21'h008001;
      5'h02: c = 21'h008181;
      5'h03: c = 21'h009002;
      5'h04: c = 21'h009004;
      5'h05: c = 21'h009008;
      5'h06: c = 21'h008800;
      5'h07: c = 21'h010200;
      5'h08: c = 21'h00A000;
      5'h09: c = 21'h004000;
      5'h0A: c = 21'h009010;
      5'h0B: c = 21'h009020;
      5'h0C: c = 21'h009040;
      5'h0D: c = 21'h000581;
      5'h0E: c = 21'h020200;
      5'h0F: c = 21'h040200;
      5'h10: c = 21'h080200;
      5'h11: c = 21'h100200;
      default: c = '0;
    endcase
    return c;
  endfunction

  typedef struct {
    logic [PCW-1:0] pc;
    logic [15:0]    instr;
  } ent_t;

  ent_t           sb[$];
  ent_t           e;
  logic           mon_on = 1'b0;
  logic           m_idv  = 1'b0;
  logic           p_adv, p_flush, p_push;
  logic [PCW-1:0] p_pc, h_pc;
  logic [15:0]    p_instr;
  logic [OPW-1:0] p_op1, p_op2, h_op1;
  logic [20:0]    h_ctrl;

  // Model state advances on each negedge using the inputs captured at the previous negedge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_idv  = 1'b0;
      mon_on = 1'b0;
    end else begin
      if (mon_on) begin
        if (p_flush) begin
          sb.delete();
          m_idv = 1'b0;
          check("flush_valid", 64'(id_valid), 64'(0));
          check("flush_ctrl", 64'(id_ctrl), 64'(0));
        end else begin
          if (p_adv) begin
            if (sb.size() > 0) begin
              e = sb.pop_front();
              m_idv = 1'b1;
              check("pop_valid", 64'(id_valid), 64'(1));
              check("pop_pc", 64'(id_pc), 64'(e.pc));
              check("pop_ctrl", 64'(id_ctrl), 64'(exp_ctrl(e.instr[15:11])));
              check("pop_res", 64'(id_res_addr), 64'(e.instr[10:8]));
              check("pop_op1a", 64'(id_op1_addr), 64'(e.instr[2:0]));
              check("pop_op2a", 64'(id_op2_addr), 64'(e.instr[6:4]));
              check("pop_ld", 64'(id_ld_addr), 64'(e.instr[7:0]));
              check("pop_st", 64'(id_st_addr), 64'(e.instr[10:3]));
              check("pop_br", 64'(id_br_target), 64'(e.instr[7:0]));
              check("pop_op1", 64'(id_op1), 64'(p_op1));
              check("pop_op2", 64'(id_op2), 64'(p_op2));
            end else begin
              m_idv = 1'b0;
              check("bubble_valid", 64'(id_valid), 64'(0));
              check("bubble_ctrl", 64'(id_ctrl), 64'(0));
            end
          end else begin
            check("hold_valid", 64'(id_valid), 64'(1));
            check("hold_pc", 64'(id_pc), 64'(h_pc));
            check("hold_ctrl", 64'(id_ctrl), 64'(h_ctrl));
            check("hold_op1", 64'(id_op1), 64'(h_op1));
          end
          if (p_push) sb.push_back('{p_pc, p_instr});
        end
        check("q_count", 64'(q_count), 64'(sb.size()));
        check("if_ready", 64'(if_ready), 64'(sb.size() < DEPTH));
        if (sb.size() > 0) begin
          check("fwd_op1", 64'(op1_addr_fwd), 64'(sb[0].instr[2:0]));
          check("fwd_op2", 64'(op2_addr_fwd), 64'(sb[0].instr[6:4]));
          check("load_fwd", 64'(load_fwd), 64'(sb[0].instr[15:11] == 5'h08));
        end else begin
          check("load_fwd_empty", 64'(load_fwd), 64'(0));
        end
      end
      p_adv   = !m_idv || !id_stall;
      p_flush = flush;
      p_push  = if_valid && (sb.size() < DEPTH) && !flush;
      p_pc    = if_pc;
      p_instr = if_instr;
      p_op1   = op1_data;
      p_op2   = op2_data;
      h_pc    = id_pc;
      h_ctrl  = id_ctrl;
      h_op1   = id_op1;
      mon_on  = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_instr();
    return 16'($urandom);
  endfunction

  logic acc;

  initial begin
    rst = 1'b1; if_valid = 0; if_pc = '0; if_instr = '0; flush = 0; id_stall = 0;
    op1_data = '0; op2_data = '0;
    step(); step();
    check("rst_ready", 64'(if_ready), 64'(1));
    check("rst_qcnt", 64'(q_count), 64'(0));
    check("rst_valid", 64'(id_valid), 64'(0));
    check("rst_pc", 64'(id_pc), 64'(0));
    check("rst_ctrl", 64'(id_ctrl), 64'(0));
    check("rst_op1", 64'(id_op1), 64'(0));
    check("rst_br", 64'(id_br_target), 64'(0));
    rst = 1'b0;
    step();

    // ADD r1,r2,r3 at pc 5
    if_valid = 1; if_pc = 8'd5; if_instr = 16'h0932;
    step();
    if_valid = 0;
    step();
    check("add_valid", 64'(id_valid), 64'(1));
    check("add_pc", 64'(id_pc), 64'(5));
    check("add_ctrl", 64'(id_ctrl), 64'(21'h008001));
    check("add_res", 64'(id_res_addr), 64'(1));

    // Fill with stall held: DEPTH accepted, extra refused
    id_stall = 1; if_pc = 8'd16;
    for (int i = 0; i <= DEPTH; i++) begin
      if_valid = 1; if_instr = rnd_instr();
      check("fill_ready", 64'(if_ready), 64'(i < DEPTH));
      acc = if_ready;
      step();
      if (acc) if_pc = if_pc + 8'd1;
    end
    check("full_qcnt", 64'(q_count), 64'(DEPTH));
    check("full_ready", 64'(if_ready), 64'(0));

    // Release stall with fetch still valid: drain across pointer wrap
    id_stall = 0;
    for (int i = 0; i < 16; i++) begin
      op1_data = OPW'($urandom); op2_data = OPW'($urandom);
      acc = if_ready;
      step();
      if (acc) begin if_pc = if_pc + 8'd1; if_instr = rnd_instr(); end
    end
    if_valid = 0;
    for (int i = 0; i < 8; i++) step();

    // Random traffic with stalls and occasional flush
    for (int i = 0; i < 200; i++) begin
      if_valid = 1'($urandom_range(0, 1));
      id_stall = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      op1_data = OPW'($urandom); op2_data = OPW'($urandom);
      acc = if_valid && if_ready && !flush;
      step();
      if (acc) begin if_pc = if_pc + 8'd1; if_instr = rnd_instr(); end
    end
    if_valid = 0; id_stall = 0; flush = 0;
    for (int i = 0; i < 8; i++) step();

    // Flush with push and stall pending, queue at 3
    if_valid = 1; if_pc = 8'd100; if_instr = 16'h0932;
    step();
    if_valid = 0;
    step();
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; if_pc = if_pc + 8'd1; if_instr = rnd_instr();
      step();
    end
    if_valid = 0;
    check("pre_flush_qcnt", 64'(q_count), 64'(3));
    flush = 1; if_valid = 1; if_pc = 8'd200; if_instr = 16'h0932;
    step();
    flush = 0; if_valid = 0;
    check("post_flush_qcnt", 64'(q_count), 64'(0));
    check("post_flush_valid", 64'(id_valid), 64'(0));
    id_stall = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flushed_gone", 64'(id_valid), 64'(0));
    end

    // JEQ with all-ones target truncated to 8 bits, operand latch and hold
    if_valid = 1; if_pc = 8'd7; if_instr = 16'h83FF;
    step();
    if_valid = 0; op1_data = 24'hABCDEF; op2_data = 24'h13579B;
    step();
    check("jeq_br", 64'(id_br_target), 64'(8'hFF));
    check("jeq_ctrl", 64'(id_ctrl), 64'(21'h080200));
    check("jeq_op1", 64'(id_op1), 64'(24'hABCDEF));
    id_stall = 1; op1_data = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_op1", 64'(id_op1), 64'(24'hABCDEF));
    end
    id_stall = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
